panel_input_hub: RTL and testbench
==================================

PANEL_INPUT_HUB -- requirements
Module: panel_input_hub

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 13: number of active-low push-button inputs.
REQ-002 SHALL have parameter NUM_ENC, default 2: number of quadrature encoder channels.
REQ-003 SHALL have parameter CNT_W, default 8: width of each encoder position counter.
REQ-004 SHALL have parameter TICK_DIV, default 128: clk cycles per sample tick (>=2).
REQ-005 SHALL have parameter DEB_TICKS, default 16: consecutive differing ticks needed to accept a key change (>=1).
REQ-006 SHALL use one clock; reset is asynchronous and active-high.
REQ-007 SHALL have port clk, input, 1: sole clock.
REQ-008 SHALL have port reset, input, 1: asynchronous active-high reset.
REQ-009 SHALL have port key_n, input, NUM_KEYS: raw buttons, 0 = pressed.
REQ-010 SHALL have port enc_a, input, NUM_ENC: encoder A phases.
REQ-011 SHALL have port enc_b, input, NUM_ENC: encoder B phases.
REQ-012 SHALL have port irq_clr, input, 1: single-cycle clear of irq.
REQ-013 SHALL have port key_state, output, NUM_KEYS: debounced state, 1 = pressed.
REQ-014 SHALL have port key_any, output, 1: OR of key_state.
REQ-015 SHALL have port enc_count, output, NUM_ENC*CNT_W: channel i at bits [i*CNT_W +: CNT_W].
REQ-016 SHALL have port irq, output, 1: sticky change indication.
REQ-017 SHALL have port enc_err, output, NUM_ENC: sticky illegal-transition flags.

Function
REQ-018 SHALL pass every key_n, enc_a and enc_b bit through a 2-flop synchronizer before use.
REQ-019 SHALL run a free-running prescaler asserting a one-cycle tick every TICK_DIV clk cycles, first tick TICK_DIV cycles after reset release.
REQ-020 SHALL, per key on each tick: if synced ~key_n differs from key_state, increment debounce count; else clear it to 0.
REQ-021 SHALL update key_state and clear count in the cycle after the tick on which count reaches DEB_TICKS; no change between ticks.
REQ-022 SHALL drive key_any combinationally from key_state.
REQ-023 SHALL, per encoder on each tick, compare synced {A,B} with previous sampled {A,B} and then store current as previous.
REQ-024 SHALL count +1 for 00->01->11->10->00 transitions and -1 for the reverse; no change on equal samples.
REQ-025 SHALL treat a both-bits-changed sample as illegal: no count change.
REQ-026 SHALL wrap counters modulo 2^CNT_W (max +1 -> 0, 0 -1 -> max).
REQ-027 SHALL on the first tick after reset only load previous {A,B}, never count or flag error.
REQ-028 SHALL set irq one cycle after any key_state bit or any enc_count value changes.
REQ-029 SHALL clear irq on irq_clr; a new event in the same cycle as irq_clr SHALL win (irq stays 1).
REQ-030 SHALL process all keys and encoders in parallel on the same tick; simultaneous events SHALL raise one irq.

Reset
REQ-031 SHALL on reset force key_state=0, key_any=0, enc_count=0, irq=0, enc_err=0, prescaler=0, debounce counts=0, synchronizers to released (key_n=1) and A/B=0.
REQ-032 SHALL abort any debounce in progress when reset asserts mid-operation; no partial state survives.

Configuration
REQ-033 SHALL with PANEL_ENC_ERR_EN defined set enc_err[i] on illegal transitions of channel i, held until irq_clr (irq_clr clears enc_err and irq together; error in same cycle wins) or reset.
REQ-034 SHALL without PANEL_ENC_ERR_EN tie enc_err to 0 and include no error logic; counting unchanged.

Verification (TICK_DIV=4, DEB_TICKS=3, CNT_W=8)
REQ-035 SHALL cover key_n[0] held 0 for 12 ticks -> key_state[0]=1 after 3rd tick, key_any=1, irq=1; glitch 0 for 2 ticks -> no change.
REQ-036 SHALL cover enc 0 stepped 00,01,11,10,00 one step per 2 ticks -> count 4; reverse sequence -> back to 0.
REQ-037 SHALL cover count 0xFF then one forward step -> 0x00; count 0x00 and one reverse step -> 0xFF.
REQ-038 SHALL cover A,B jump 00->11 -> count unchanged, enc_err[0]=1 with macro, 0 without.
REQ-039 SHALL cover irq_clr coincident with a key change -> irq remains 1; irq_clr alone -> irq 0 next cycle.
REQ-040 SHALL cover reset asserted mid-debounce (count=2) -> all outputs 0 immediately, key needs 3 fresh ticks after release.

Source files
------------

// File: rtl/panel_input_hub.sv
// Front-panel input hub: debounced active-low keys, quadrature encoder counters, sticky irq.
// Define PANEL_ENC_ERR_EN to build the sticky illegal-transition flags on enc_err.
module panel_input_hub #(
   parameter int NUM_KEYS  = 13,
   parameter int NUM_ENC   = 2,
   parameter int CNT_W     = 8,
   parameter int TICK_DIV  = 128,
   parameter int DEB_TICKS = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_KEYS-1:0]      key_n,
   input  logic [NUM_ENC-1:0]       enc_a,
   input  logic [NUM_ENC-1:0]       enc_b,
   input  logic                     irq_clr,
   output logic [NUM_KEYS-1:0]      key_state,
   output logic                     key_any,
   output logic [NUM_ENC*CNT_W-1:0] enc_count,
   output logic                     irq,
   output logic [NUM_ENC-1:0]       enc_err
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int DW = $clog2(DEB_TICKS + 1);
   localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
   localparam logic [DW-1:0] DEB_DONE  = DW'(DEB_TICKS);

   // Position of an {A,B} sample on the 00->01->11->10 ring.
   function automatic logic [1:0] phase_idx(input logic a, input logic b);
      return {a, a ^ b};
   endfunction

   // Ring distance 1 is a forward step, 3 a reverse step; 0 and 2 leave the count alone.
   function automatic logic [CNT_W-1:0] wrap_step(input logic [CNT_W-1:0] v, input logic [1:0] d);
      case (d)
         2'd1:    return v + CNT_W'(1);
         2'd3:    return v - CNT_W'(1);
         default: return v;
      endcase
   endfunction

   logic [NUM_KEYS-1:0] key_p0, key_p1;
   logic [NUM_ENC-1:0]  a_p0, a_p1, b_p0, b_p1;

   // Stage p0/p1: two-flop synchronizers, released state is key up and A/B low
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         key_p0 <= '1;
         key_p1 <= '1;
         a_p0   <= '0;
         a_p1   <= '0;
         b_p0   <= '0;
         b_p1   <= '0;
      end else begin
         key_p0 <= key_n;
         key_p1 <= key_p0;
         a_p0   <= enc_a;
         a_p1   <= a_p0;
         b_p0   <= enc_b;
         b_p1   <= b_p0;
      end
   end

   logic [PW-1:0] presc;
   logic          tick;

   assign tick = (presc == TICK_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)     presc <= '0;
      else if (tick) presc <= '0;
      else           presc <= presc + PW'(1);
   end

   logic [DW-1:0] deb_cnt [NUM_KEYS];

   // State flips the cycle after the count reaches DEB_DONE, so it never collides with a tick.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         key_state <= '0;
         for (int i = 0; i < NUM_KEYS; i++) deb_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_KEYS; i++) begin
            if (deb_cnt[i] == DEB_DONE) begin
               key_state[i] <= ~key_state[i];
               deb_cnt[i]   <= '0;
            end else if (tick) begin
               if (key_p1[i] == key_state[i]) deb_cnt[i] <= deb_cnt[i] + DW'(1);
               else                           deb_cnt[i] <= '0;
            end
         end
      end
   end

   assign key_any = |key_state;

   logic [NUM_ENC-1:0] prev_a, prev_b;
   logic               prev_vld;
   logic [CNT_W-1:0]   cnt [NUM_ENC];
   logic [1:0]         dir [NUM_ENC];

   always_comb begin
      for (int i = 0; i < NUM_ENC; i++)
         dir[i] = phase_idx(a_p1[i], b_p1[i]) - phase_idx(prev_a[i], prev_b[i]);
   end

   // The first tick after reset only captures the reference sample.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_a   <= '0;
         prev_b   <= '0;
         prev_vld <= 1'b0;
         for (int i = 0; i < NUM_ENC; i++) cnt[i] <= '0;
      end else if (tick) begin
         prev_a   <= a_p1;
         prev_b   <= b_p1;
         prev_vld <= 1'b1;
         if (prev_vld) begin
            for (int i = 0; i < NUM_ENC; i++) cnt[i] <= wrap_step(cnt[i], dir[i]);
         end
      end
   end

   for (genvar gi = 0; gi < NUM_ENC; gi++) begin : g_cnt_out
      assign enc_count[gi*CNT_W +: CNT_W] = cnt[gi];
   end

   logic [NUM_KEYS-1:0]      key_state_d;
   logic [NUM_ENC*CNT_W-1:0] enc_count_d;
   logic                     chg;

   assign chg = (key_state != key_state_d) || (enc_count != enc_count_d);

   // Any output change raises irq one cycle later and beats a coincident clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         key_state_d <= '0;
         enc_count_d <= '0;
         irq         <= 1'b0;
      end else begin
         key_state_d <= key_state;
         enc_count_d <= enc_count;
         if (chg)          irq <= 1'b1;
         else if (irq_clr) irq <= 1'b0;
      end
   end

`ifdef PANEL_ENC_ERR_EN
   logic [NUM_ENC-1:0] err_hit;

   always_comb begin
      for (int i = 0; i < NUM_ENC; i++)
         err_hit[i] = tick && prev_vld && (dir[i] == 2'd2);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) enc_err <= '0;
      else       enc_err <= err_hit | (enc_err & ~{NUM_ENC{irq_clr}});
   end
`else
   assign enc_err = '0;
`endif

endmodule

// File: tb/tb_panel_input_hub.sv
// Self-checking bench for panel_input_hub with a tick-level behavioural model of keys, encoders and irq.
module tb_panel_input_hub;

   localparam int NK = 13;
   localparam int NE = 2;
   localparam int CW = 8;
   localparam int TD = 4;
   localparam int DT = 3;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic [NK-1:0]     key_n = '1;
   logic [NE-1:0]     enc_a = '0;
   logic [NE-1:0]     enc_b = '0;
   logic              irq_clr = 1'b0;
   logic [NK-1:0]     key_state;
   logic              key_any;
   logic [NE*CW-1:0]  enc_count;
   logic              irq;
   logic [NE-1:0]     enc_err;

   panel_input_hub #(
      .NUM_KEYS(NK), .NUM_ENC(NE), .CNT_W(CW), .TICK_DIV(TD), .DEB_TICKS(DT)
   ) dut (
      .clk(clk), .reset(reset), .key_n(key_n), .enc_a(enc_a), .enc_b(enc_b),
      .irq_clr(irq_clr), .key_state(key_state), .key_any(key_any),
      .enc_count(enc_count), .irq(irq), .enc_err(enc_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state, advanced once per sample tick.
   logic [NK-1:0] st_m;
   int            dc_m [NK];
   int            pos_m [NE];
   logic [1:0]    prev_m [NE];
   logic          prev_vld_m;
   logic          irq_m;
   logic [NE-1:0] err_m;
   logic          ev_key, ev_enc;

   logic [1:0] fwd_seq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
   logic [1:0] rev_seq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};

   function automatic int ring_pos(input logic [1:0] ab);
      case (ab)
         2'b00:   return 0;
         2'b01:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   task automatic model_reset();
      st_m = '0;
      for (int k = 0; k < NK; k++) dc_m[k] = 0;
      for (int e = 0; e < NE; e++) begin
         pos_m[e]  = 0;
         prev_m[e] = 2'b00;
      end
      prev_vld_m = 1'b0;
      irq_m      = 1'b0;
      err_m      = '0;
      ev_key     = 1'b0;
      ev_enc     = 1'b0;
   endtask

   task automatic model_update();
      logic [1:0] cur;
      int         d;
      ev_key = 1'b0;
      ev_enc = 1'b0;
      for (int k = 0; k < NK; k++) begin
         if ((!key_n[k]) != st_m[k]) dc_m[k] = dc_m[k] + 1;
         else                        dc_m[k] = 0;
         if (dc_m[k] == DT) begin
            st_m[k] = !st_m[k];
            dc_m[k] = 0;
            ev_key  = 1'b1;
         end
      end
      for (int e = 0; e < NE; e++) begin
         cur = {enc_a[e], enc_b[e]};
         if (prev_vld_m) begin
            d = (ring_pos(cur) - ring_pos(prev_m[e]) + 4) % 4;
            if (d == 1) begin
               pos_m[e] = (pos_m[e] + 1) % 256;
               ev_enc   = 1'b1;
            end else if (d == 3) begin
               pos_m[e] = (pos_m[e] + 255) % 256;
               ev_enc   = 1'b1;
            end else if (d == 2) begin
               err_m[e] = 1'b1;
            end
         end
         prev_m[e] = cur;
      end
      prev_vld_m = 1'b1;
   endtask

   task automatic check_all(input string tag);
      logic [NE*CW-1:0] exp_cnt;
      logic [NE-1:0]    exp_err;
      for (int e = 0; e < NE; e++) exp_cnt[e*CW +: CW] = CW'(pos_m[e]);
`ifdef PANEL_ENC_ERR_EN
      exp_err = err_m;
`else
      exp_err = '0;
`endif
      checks++;
      assert (key_state === st_m) else begin
         errors++;
         $error("FAIL %s.key_state got %h expected %h", tag, key_state, st_m);
      end
      checks++;
      assert (key_any === (|st_m)) else begin
         errors++;
         $error("FAIL %s.key_any got %b expected %b", tag, key_any, |st_m);
      end
      checks++;
      assert (enc_count === exp_cnt) else begin
         errors++;
         $error("FAIL %s.enc_count got %h expected %h", tag, enc_count, exp_cnt);
      end
      checks++;
      assert (irq === irq_m) else begin
         errors++;
         $error("FAIL %s.irq got %b expected %b", tag, irq, irq_m);
      end
      checks++;
      assert (enc_err === exp_err) else begin
         errors++;
         $error("FAIL %s.enc_err got %b expected %b", tag, enc_err, exp_err);
      end
   endtask

   // Entered just after a tick edge; optional irq_clr pulse on edge offset clr_at (1..TD-1),
   // check before the next tick edge, then advance the model across that edge.
   task automatic tick(input string tag, input int clr_at);
      for (int o = 1; o < TD; o++) begin
         irq_clr = (o == clr_at);
         @(posedge clk);
         if ((o == 1 && ev_enc) || (o == 2 && ev_key)) irq_m = 1'b1;
         else if (o == clr_at)                         irq_m = 1'b0;
         if (o == clr_at) err_m = '0;
         @(negedge clk);
      end
      irq_clr = 1'b0;
      check_all(tag);
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset   = 1'b1;
      irq_clr = 1'b0;
      model_reset();
      #1;
      check_all("reset");
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic enc_set(input int ch, input logic [1:0] ab);
      enc_a[ch] = ab[1];
      enc_b[ch] = ab[0];
   endtask

   initial begin
      do_reset();
      repeat (2) tick("idle", 0);

      key_n[0] = 1'b0;
      repeat (12) tick("key_hold", 0);
      key_n[1] = 1'b0;
      repeat (2) tick("glitch", 0);
      key_n[1] = 1'b1;
      repeat (3) tick("glitch_end", 0);

      tick("clr_alone", 1);
      key_n[0] = 1'b1;
      for (int i = 0; i < 5; i++) tick("clr_coinc", (i == 3) ? 2 : 0);

      for (int i = 0; i < 4; i++) begin
         enc_set(0, fwd_seq[i]);
         repeat (2) tick("enc_fwd", 0);
      end
      for (int i = 0; i < 4; i++) begin
         enc_set(0, rev_seq[i]);
         repeat (2) tick("enc_rev", (i == 1) ? 3 : 0);
      end

      enc_set(0, 2'b10);
      repeat (2) tick("wrap_dn", 0);
      enc_set(0, 2'b00);
      repeat (2) tick("wrap_up", 0);

      enc_set(0, 2'b11);
      repeat (2) tick("illegal", 0);
      tick("err_clr", 1);
      enc_set(1, 2'b01);
      repeat (2) tick("enc1_fwd", 0);

      for (int i = 0; i < 60; i++) begin
         key_n = key_n ^ NK'($urandom & $urandom & $urandom);
         if ($urandom_range(0, 1) == 1) begin
            enc_a = NE'($urandom);
            enc_b = NE'($urandom);
         end
         tick("rand", int'($urandom_range(0, 3)));
      end

      key_n = '1;
      enc_a = '0;
      enc_b = '0;
      repeat (5) tick("settle", 1);

      key_n[2] = 1'b0;
      repeat (2) tick("pre_rst", 0);
      do_reset();
      repeat (5) tick("post_rst", 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
